// File: rtl/lab1_stim_gen.sv
// Burst stimulus generator: emits i_count Q2.14 samples x_start + k*step over a
// valid/ready handshake, then pulses o_done for one cycle.
module lab1_stim_gen #(
    parameter int WIDTHIN  = 16,
    parameter int WIDTHCNT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic [WIDTHIN-1:0]  i_x_start,
    input  logic [WIDTHIN-1:0]  i_x_step,
    input  logic [WIDTHCNT-1:0] i_count,
    input  logic                i_ready,
    output logic                o_valid,
    output logic [WIDTHIN-1:0]  o_x,
    output logic                o_busy,
    output logic                o_done,
    output logic [WIDTHCNT-1:0] o_sent
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t              state_q, state_nxt;
    logic [WIDTHIN-1:0]  x_q, x_nxt;
    logic [WIDTHIN-1:0]  step_q, step_nxt;
    logic [WIDTHCNT-1:0] rem_q, rem_nxt;
    logic [WIDTHCNT-1:0] sent_q, sent_nxt;
    logic                valid_q, valid_nxt;
    logic                done_q, done_nxt;
    logic                busy_q, busy_nxt;
    logic                xfer;

    assign xfer = valid_q & i_ready;

    always_comb begin
        state_nxt = state_q;
        x_nxt     = x_q;
        step_nxt  = step_q;
        rem_nxt   = rem_q;
        sent_nxt  = sent_q;
        valid_nxt = valid_q;
        done_nxt  = 1'b0;

        case (state_q)
            IDLE: begin
                valid_nxt = 1'b0;
                if (i_start) begin
                    x_nxt    = i_x_start;
                    step_nxt = i_x_step;
                    rem_nxt  = i_count;
                    sent_nxt = '0;
                    if (i_count == '0) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = SEND;
                        valid_nxt = 1'b1;
                    end
                end
            end
            SEND: begin
                if (xfer) begin
                    x_nxt    = x_q + step_q;
                    rem_nxt  = rem_q - 1'b1;
                    sent_nxt = sent_q + 1'b1;
                end
                // A transfer on the abort edge is still counted above.
                if ((xfer && rem_q == WIDTHCNT'(1)) || i_abort) begin
                    state_nxt = DONE;
                    valid_nxt = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                valid_nxt = 1'b0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            step_q  <= '0;
            rem_q   <= '0;
            sent_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            x_q     <= x_nxt;
            step_q  <= step_nxt;
            rem_q   <= rem_nxt;
            sent_q  <= sent_nxt;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
            busy_q  <= busy_nxt;
        end
    end

    assign o_valid = valid_q;
    assign o_x     = x_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_sent  = sent_q;

endmodule

// File: tb/tb_lab1_stim_gen.sv
// Scoreboard bench for lab1_stim_gen: the driver predicts samples and done
// events from the burst rules; a negedge monitor pops and compares them.
module tb_lab1_stim_gen;

    localparam int WI = 16;
    localparam int WC = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start, i_abort, i_ready;
    logic [WI-1:0] i_x_start, i_x_step;
    logic [WC-1:0] i_count;
    logic          o_valid, o_busy, o_done;
    logic [WI-1:0] o_x;
    logic [WC-1:0] o_sent;

    int checks = 0;
    int errors = 0;

    logic [WI-1:0] exp_x_q[$];
    logic [WC-1:0] exp_done_q[$];

    always #5 clk = ~clk;

    lab1_stim_gen #(.WIDTHIN(WI), .WIDTHCNT(WC)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_abort  (i_abort),
        .i_x_start(i_x_start),
        .i_x_step (i_x_step),
        .i_count  (i_count),
        .i_ready  (i_ready),
        .o_valid  (o_valid),
        .o_x      (o_x),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_sent   (o_sent)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a transfer is committed at the next posedge when valid&&ready here.
    logic          hold_v = 1'b0;
    logic [WI-1:0] hold_x = '0;
    always @(negedge clk) begin
        if (!reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && o_valid) chk("x_stable_while_stalled", 32'(o_x), 32'(hold_x));
            if (o_valid && i_ready) begin
                if (exp_x_q.size() == 0) chk("unexpected_transfer", 32'(o_x), 32'hFFFF_FFFF);
                else chk("sample", 32'(o_x), 32'(exp_x_q.pop_front()));
            end
            if (o_done) begin
                if (exp_done_q.size() == 0) chk("unexpected_done", 32'(o_sent), 32'hFFFF_FFFF);
                else chk("sent_at_done", 32'(o_sent), 32'(exp_done_q.pop_front()));
            end
            hold_v = o_valid && !i_ready;
            hold_x = o_x;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 = ready always 1, 1 = random ready, 2 = ready pattern 1,0,0,1,0,1
    // abort_at: abort on the edge of transfer number abort_at+1 (-1: never)
    task automatic burst(input logic [WI-1:0] xs, input logic [WI-1:0] st,
                         input logic [WC-1:0] cnt, input int mode, input int abort_at);
        int          sent;
        int          c;
        logic        rdy, ab;
        logic [5:0]  pat;
        logic [WI-1:0] ex;
        pat = 6'b101001;
        sent = 0;
        c = 0;
        i_start = 1'b1; i_x_start = xs; i_x_step = st; i_count = cnt;
        i_abort = 1'b0;
        tick();
        i_start = 1'b0;
        i_x_start = WI'($urandom); i_x_step = WI'($urandom); i_count = WC'($urandom);
        chk("valid_latency", 32'(o_valid), 32'(cnt != '0));
        chk("busy_after_start", 32'(o_busy), 1);
        chk("sent_cleared", 32'(o_sent), 0);
        if (cnt != '0) begin
            while (1) begin
                if (mode == 0) rdy = 1'b1;
                else if (mode == 1) rdy = 1'($urandom_range(0, 1));
                else rdy = pat[c % 6];
                ab = (abort_at >= 0) && (sent == abort_at) && rdy;
                i_ready = rdy;
                i_abort = ab;
                i_start = 1'($urandom_range(0, 1));
                chk("valid_in_send", 32'(o_valid), 1);
                if (rdy) begin
                    ex = xs + WI'(sent) * st;
                    exp_x_q.push_back(ex);
                end
                tick();
                c++;
                if (rdy) sent++;
                if (sent == int'(cnt) || ab) break;
            end
        end
        exp_done_q.push_back(WC'(sent));
        i_start = 1'b0;
        i_abort = 1'($urandom_range(0, 1));
        i_ready = 1'($urandom_range(0, 1));
        chk("valid_low_in_done", 32'(o_valid), 0);
        chk("done_pulse", 32'(o_done), 1);
        chk("busy_in_done", 32'(o_busy), 1);
        chk("sent_count", 32'(o_sent), 32'(sent));
        tick();
        i_abort = 1'b0;
        chk("done_one_cycle", 32'(o_done), 0);
        chk("busy_idle", 32'(o_busy), 0);
        chk("valid_idle", 32'(o_valid), 0);
        tick();
        chk("sent_hold_idle", 32'(o_sent), 32'(sent));
        chk("samples_drained", 32'(exp_x_q.size()), 0);
        chk("done_drained", 32'(exp_done_q.size()), 0);
    endtask

    task automatic reset_mid_burst();
        i_start = 1'b1; i_x_start = 16'h1234; i_x_step = 16'h0011; i_count = 16'd6;
        i_ready = 1'b1; i_abort = 1'b0;
        tick();
        i_start = 1'b0;
        exp_x_q.push_back(16'h1234);
        tick();
        exp_x_q.push_back(16'h1245);
        tick();
        chk("sent_before_reset", 32'(o_sent), 2);
        reset = 1'b0;
        #1;
        chk("rst_async_valid", 32'(o_valid), 0);
        chk("rst_async_x", 32'(o_x), 0);
        chk("rst_async_busy", 32'(o_busy), 0);
        chk("rst_async_done", 32'(o_done), 0);
        chk("rst_async_sent", 32'(o_sent), 0);
        chk("rst_samples_drained", 32'(exp_x_q.size()), 0);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("no_start_after_reset", 32'(o_valid), 0);
            chk("idle_after_reset", 32'(o_busy), 0);
        end
        burst(16'h4000, 16'h0100, 16'd1, 0, -1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
        i_x_start = '0; i_x_step = '0; i_count = '0;
        #1;
        chk("reset_valid", 32'(o_valid), 0);
        chk("reset_x", 32'(o_x), 0);
        chk("reset_busy", 32'(o_busy), 0);
        chk("reset_done", 32'(o_done), 0);
        chk("reset_sent", 32'(o_sent), 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("idle_no_start", 32'(o_busy), 0);

        burst(16'h0000, 16'h0400, 16'd4, 0, -1);
        burst(WI'($urandom), WI'($urandom), 16'd3, 2, -1);
        burst(16'hFF00, 16'h0200, 16'd2, 0, -1);
        burst(16'h5555, 16'h0001, 16'd0, 0, -1);
        burst(16'h0100, 16'h0010, 16'd10, 0, 3);
        reset_mid_burst();

        for (int n = 0; n < 30; n++) begin
            int cnt_r;
            int ab_r;
            cnt_r = $urandom_range(0, 20);
            ab_r = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 20) : -1;
            burst(WI'($urandom), WI'($urandom), WC'(cnt_r), 1, ab_r);
        end

        burst(16'h0003, 16'h0007, 16'hFFFF, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lab1_stim_gen.md
LAB1_STIM_GEN -- requirements
Module: lab1_stim_gen

Interface
REQ-001 Parameter: WIDTHIN, 16, sample width in Q2.14 format.
REQ-002 Parameter: WIDTHCNT, 16, width of the sample-count and sent-count fields.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports SHALL be exactly as follows:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- i_start  input  1  one-cycle start request, sampled only in IDLE.
- i_abort  input  1  stop the burst early, sampled only in SEND.
- i_x_start  input  WIDTHIN  first sample value.
- i_x_step  input  WIDTHIN  increment between samples, modulo 2^WIDTHIN.
- i_count  input  WIDTHCNT  number of samples in the burst.
- i_ready  input  1  downstream can accept a sample (connects to the exp pipeline's o_ready).
- o_valid  output  1  o_x holds a sample on offer.
- o_x  output  WIDTHIN  sample on offer (connects to the pipeline's i_x).
- o_busy  output  1  state is not IDLE.
- o_done  output  1  one-cycle burst-complete pulse.
- o_sent  output  WIDTHCNT  number of accepted transfers in the current or last burst.

Function
REQ-005 The state machine SHALL have exactly three states: IDLE, SEND, DONE.
REQ-006 A transfer SHALL occur on a rising edge where o_valid=1 and i_ready=1.
REQ-007 IDLE with i_start=1 SHALL do all of the following at that edge:
- latch i_x_start, i_x_step and i_count;
- clear o_sent to 0;
- if i_count=0, go to DONE;
- otherwise go to SEND with o_valid=1 and o_x=i_x_start.
REQ-008 i_start SHALL be ignored in SEND and DONE, and parameter inputs SHALL be ignored except at an accepted start.
REQ-009 In SEND, o_valid SHALL stay 1 and o_x SHALL stay stable until a transfer occurs, for any duration of i_ready=0.
REQ-010 On each transfer, at that edge, the block SHALL:
- add the latched step to o_x, wrapping modulo 2^WIDTHIN;
- decrement the remaining count;
- increment o_sent.
REQ-011 With i_ready held at 1, the block SHALL sustain one transfer per cycle with no bubbles.
REQ-012 On the transfer of the final sample, at that edge, the block SHALL clear o_valid to 0 and go to DONE.
REQ-013 i_abort=1 in SEND SHALL, at that edge, clear o_valid to 0 and go to DONE.
REQ-014 If a transfer coincides with i_abort=1, the transfer SHALL complete and be counted before the abort takes effect.
REQ-015 In DONE, o_done SHALL be 1 for exactly one cycle, and the next edge SHALL return the state to IDLE.
REQ-016 o_valid SHALL be 0 in IDLE and DONE.
REQ-017 o_sent SHALL hold its value in IDLE until the next accepted start.
REQ-018 o_busy SHALL be 1 exactly while the state is SEND or DONE.
REQ-019 Latency from the i_start edge to o_valid=1 SHALL be one cycle; o_valid is high in the cycle after that edge.
REQ-020 i_count = 2^WIDTHCNT-1 SHALL produce exactly that many transfers with no counter overflow.
REQ-021 All outputs SHALL be registered, with no combinational path from i_ready to o_valid.

Reset
REQ-022 While reset=0, the block SHALL force the state to IDLE and all of o_valid, o_x, o_busy, o_done and o_sent to 0, asynchronously and without waiting for a clock edge.
REQ-023 Reset asserted mid-burst SHALL discard the burst, and no transfer SHALL occur until a new i_start after reset is released.
REQ-024 After reset release, the block SHALL wait in IDLE and SHALL NOT start without i_start.

Verification
REQ-025 Start, x_start=0x0000, step=0x0400, count=4, i_ready=1 throughout -> o_x sequence 0x0000, 0x0400, 0x0800, 0x0C00 on 4 consecutive cycles; o_done one cycle later; o_sent=4.
REQ-026 count=3, i_ready toggling 1,0,0,1,0,1 -> exactly 3 transfers; o_x constant while i_ready=0; values x_start, x_start+step, x_start+2*step.
REQ-027 x_start=0xFF00, step=0x0200, count=2 -> o_x 0xFF00 then 0x0100 (wrap).
REQ-028 count=0 -> o_valid never 1; o_done pulses in the cycle after the start edge; o_sent=0.
REQ-029 count=10, i_abort asserted on the 4th transfer edge -> o_sent=4; o_valid low in the next cycle; o_done pulse follows.
REQ-030 reset driven low mid-burst with o_sent=2 -> all outputs 0 immediately; i_start re-issued with count=1 after release -> one transfer; o_sent=1.
